// File: rtl/dtw_pkg.sv
// dtw_pkg: shared requester ids, arbiter state encoding and pointer rotation helper.
package dtw_pkg;
    localparam int REQ_HOST = 0;
    localparam int REQ_CTRL = 1;
    localparam int REQ_BT   = 2;
    localparam int NREQ     = 3;

    typedef enum logic {IDLE, BURST} arb_state_t;

    function automatic logic [1:0] rr_next(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction
endpackage

// File: rtl/dtw_rr_pick.sv
// dtw_rr_pick: combinational rotating-priority picker over three requesters.
module dtw_rr_pick
    import dtw_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] win,
    output logic [1:0] idx
);
    logic [1:0] c1, c2;
    always_comb begin
        c1  = rr_next(ptr);
        c2  = rr_next(c1);
        idx = req[ptr] ? ptr : req[c1] ? c1 : c2;
        win = (req == 3'b000) ? 3'b000 : 3'b001 << idx;
    end
endmodule

// File: rtl/dtw_mem_arb.sv
// dtw_mem_arb: round-robin burst arbiter for the shared template/result SRAM port.
// Optional DTW_ARB_STATS_EN adds accepted-beat and worst-wait statistics outputs.
module dtw_mem_arb
    import dtw_pkg::*;
#(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [2:0]    req_i,
    input  logic [2:0]    we_i,
    input  logic [2:0]    last_i,
    input  logic [3*AW-1:0] addr_i,
    input  logic [3*DW-1:0] wdata_i,
    output logic [2:0]    gnt_o,
    output logic [2:0]    rvalid_o,
    output logic [DW-1:0] rdata_o,
    output logic [AW-1:0] addr_o,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic          data_tri_ena,
    output logic          WR_o,
    output logic          CS_o
`ifdef DTW_ARB_STATS_EN
    ,
    output logic [3*16-1:0] stat_gnt_o,
    output logic [15:0]     stat_wait_o
`endif
);
    arb_state_t state;
    logic [1:0] ptr, own, win_idx;
    logic [2:0] win, rd_tag;
    logic [7:0] bcnt;
    logic       acc;

    dtw_rr_pick u_pick (.req(req_i), .ptr(ptr), .win(win), .idx(win_idx));

    assign acc     = (state == BURST) && req_i[own];
    // The SRAM drives data_i in the cycle after the strobe, so read data passes straight through.
    assign rdata_o = (rvalid_o != 3'b000) ? data_i : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            ptr          <= '0;
            own          <= '0;
            bcnt         <= '0;
            gnt_o        <= '0;
            rd_tag       <= '0;
            rvalid_o     <= '0;
            addr_o       <= '0;
            data_o       <= '0;
            data_tri_ena <= 1'b0;
            WR_o         <= 1'b0;
            CS_o         <= 1'b0;
        end else begin
            CS_o         <= acc;
            WR_o         <= acc && we_i[own];
            data_tri_ena <= acc && we_i[own];
            rd_tag       <= (acc && !we_i[own]) ? gnt_o : 3'b000;
            rvalid_o     <= rd_tag;
            if (state == IDLE) begin
                if (req_i != 3'b000) begin
                    gnt_o <= win;
                    own   <= win_idx;
                    bcnt  <= '0;
                    ptr   <= rr_next(win_idx);
                    state <= BURST;
                end
            end else if (acc) begin
                addr_o <= addr_i[own*AW +: AW];
                data_o <= wdata_i[own*DW +: DW];
                bcnt   <= bcnt + 8'd1;
                if (last_i[own] || bcnt == 8'(MAX_BURST - 1)) begin
                    gnt_o <= '0;
                    state <= IDLE;
                end
            end else begin
                gnt_o <= '0;
                state <= IDLE;
            end
        end
    end

`ifdef DTW_ARB_STATS_EN
    logic [15:0] wcnt [NREQ];
    logic [15:0] wnx  [NREQ];
    logic [15:0] wmax;
    always_comb begin
        wmax = stat_wait_o;
        for (int i = 0; i < NREQ; i++) begin
            wnx[i] = (req_i[i] && !gnt_o[i]) ? ((wcnt[i] == 16'hFFFF) ? wcnt[i] : wcnt[i] + 16'd1) : 16'd0;
            if (wnx[i] > wmax) wmax = wnx[i];
        end
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NREQ; i++) wcnt[i] <= '0;
            stat_gnt_o  <= '0;
            stat_wait_o <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) wcnt[i] <= wnx[i];
            stat_wait_o <= wmax;
            if (acc && stat_gnt_o[own*16 +: 16] != 16'hFFFF)
                stat_gnt_o[own*16 +: 16] <= stat_gnt_o[own*16 +: 16] + 16'd1;
        end
    end
`endif
endmodule

// File: doc/dtw_mem_arb.md
# dtw_mem_arb

Round-robin arbiter sharing the single template/result SRAM port among three requesters: host template loader (0), DTW controller template/reference reads (1), and backtrace result writer (2). It sits between those requesters and the top-level SRAM pins (address, read data, write data, tri-state enable, write strobe, chip select). It grants bursts, registers all SRAM-side outputs, and routes synchronous read data back with a per-requester valid.

## Interface
- AW, 10, SRAM address width
- DW, 32, SRAM data width
- MAX_BURST, 8, maximum beats per grant before forced release (range 1..255)
- clk  in  1  clock, all logic on rising edge
- nrst  in  1  asynchronous active-low reset
- req_i  in  3  per-requester request; bit k = requester k
- we_i  in  3  per-requester beat direction, 1 = write
- last_i  in  3  per-requester final beat of burst
- addr_i  in  3*AW  per-requester address, slice k = [k*AW +: AW]
- wdata_i  in  3*DW  per-requester write data, slice k = [k*DW +: DW]
- gnt_o  out  3  one-hot grant, registered
- rvalid_o  out  3  one-hot read-data valid
- rdata_o  out  DW  read data, shared, qualified by rvalid_o
- addr_o  out  AW  SRAM address, registered
- data_i  in  DW  SRAM read data, valid one cycle after a read strobe
- data_o  out  DW  SRAM write data, registered
- data_tri_ena  out  1  high on write-strobe cycles only
- WR_o  out  1  SRAM write strobe, high = write
- CS_o  out  1  SRAM chip select, high = access

## Operation
- States: IDLE, BURST.
- IDLE: if any req_i bit is set, pick the first requester at or after rotating pointer ptr (order ptr, ptr+1, ptr+2 mod 3). Register gnt_o one-hot and clear beat counter bcnt. Go to BURST. ptr <= winner+1 mod 3.
- BURST, granted k, req_i[k]=1: the beat is accepted. Next cycle: CS_o=1, WR_o=we_i[k], addr_o=addr_i slice k, data_o=wdata_i slice k, data_tri_ena=we_i[k]. bcnt increments.
- Release condition on an accepted beat: last_i[k]=1 or bcnt reaches MAX_BURST-1. gnt_o clears next cycle, return to IDLE. Re-arbitration takes one IDLE cycle, so there is at most one grant change per two cycles.
- BURST with req_i[k]=0: no access. gnt_o clears and state goes to IDLE.
- Forced release leaves ptr advanced past k. If k is the sole requester, it is re-granted after the IDLE cycle.
- Read return: a read strobe cycle (CS_o=1, WR_o=0) for requester k produces rvalid_o[k]=1 and rdata_o=data_i on the following cycle. The tag pipeline is independent of the grant, so reads complete after release.
- Requests from non-granted requesters are ignored; they must hold req_i until granted.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, addr_o=0, data_o=0, data_tri_ena=0, WR_o=0, CS_o=0, ptr=0, state IDLE, bcnt=0.
- Reset asserted mid-burst: all outputs go to reset values immediately. In-flight read tags are discarded, and no rvalid_o follows reset release.

## Timing
- Request in IDLE cycle N: gnt_o at N+1. First beat accepted at N+1, SRAM strobe at N+2, read data/rvalid_o at N+3.
- Throughput: one beat per cycle within a burst.
- Write: data_tri_ena, WR_o, CS_o high in the same cycle, for exactly one cycle per beat.
- rvalid_o is at most one-hot.
- WR_o and data_tri_ena never high without CS_o.

## Configuration
- DTW_ARB_STATS_EN defined: adds output stat_gnt_o (3*16), per-requester saturating counts of accepted beats, and output stat_wait_o (16), the saturating maximum number of consecutive cycles any requester held req_i ungranted. Both reset to 0.
- Not defined: those ports and counters do not exist. Arbitration behaviour is identical either way.

## Structure
- Package dtw_pkg: REQ_HOST=0, REQ_CTRL=1, REQ_BT=2, NREQ=3, arbiter state enum {IDLE, BURST}.
- Sub-module dtw_rr_pick: combinational rotating-priority picker. Inputs are req (3) and ptr (2); outputs are one-hot winner and winner index.

## Test plan
- Reset then req_i=3'b111 together, last_i on first beat each -> grants in order 0,1,2, ptr then 0; each grant 2 cycles apart.
- Requester 1 reads addr 0x005, SRAM returns 0xDEADBEEF -> CS_o=1,WR_o=0 at N+2; rvalid_o=3'b010, rdata_o=0xDEADBEEF at N+3.
- Requester 2 writes 0x0000_00AB to 0x3FF -> one cycle with CS_o=WR_o=data_tri_ena=1, addr_o=0x3FF, data_o=0xAB; no rvalid_o.
- Requester 0 holds req 20 beats without last, requester 2 requesting, MAX_BURST=8 -> 8 beats for 0, then 8 for 2 (no last), then 0 resumes.
- nrst pulsed low during burst with a read in flight -> all outputs 0 immediately; no rvalid_o after release; next request granted normally.
- DTW_ARB_STATS_EN: 5 beats from 1, requester 0 waiting 6 cycles -> stat_gnt_o slice 1 = 5, stat_wait_o = 6.
